// File: rtl/param_stack_pkg.sv
// Shared types and defaults for the parameterised LIFO/FIFO stack.
// Optional FIFO behaviour is enabled with PARAM_STACK_FIFO_MODE_EN.
package param_stack_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } op_e;

    typedef enum logic {
        LIFO = 1'b0,
        FIFO = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/param_stack_mem.sv
// Register array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module param_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parameterised stack with sticky overflow/underflow flags.
// Define PARAM_STACK_FIFO_MODE_EN to add mode_i and FIFO operation.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
`ifdef PARAM_STACK_FIFO_MODE_EN
    input  logic                       mode_i,
`endif
    input  logic                       clr_err_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [CW-1:0] CONE  = CW'(1);
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    logic [AW-1:0]    wp;
    logic [CW-1:0]    count;
    logic             ovf, udf;
    logic             empty, full;
    logic             is_fifo;
    logic             ovf_set, udf_set;
    logic             we;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] rdata;
    op_e              op;

`ifdef PARAM_STACK_FIFO_MODE_EN
    logic [AW-1:0] rp;
    mode_e         mode_q;
    assign is_fifo = (mode_q == FIFO);
    assign raddr   = is_fifo ? rp : wp - ONE;
`else
    assign is_fifo = 1'b0;
    assign raddr   = wp - ONE;
`endif

    assign empty = (count == '0);
    assign full  = (count == CFULL);

    // Classify this cycle's request; push+pop on empty degrades to push
    always_comb begin
        op = NONE;
        if (push_i && pop_i && !empty) op = REPLACE;
        else if (push_i && !full)      op = PUSH;
        else if (pop_i && !push_i && !empty) op = POP;
    end

    assign ovf_set = push_i && !pop_i && full;
    assign udf_set = pop_i && !push_i && empty;

    assign we    = (op == PUSH) || (op == REPLACE);
    assign waddr = (op == REPLACE && !is_fifo) ? wp - ONE : wp;

    param_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_i),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Pointers, occupancy, sticky flags and latched mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
`ifdef PARAM_STACK_FIFO_MODE_EN
            rp     <= '0;
            mode_q <= LIFO;
`endif
        end else begin
            ovf <= ovf_set | (ovf & ~clr_err_i);
            udf <= udf_set | (udf & ~clr_err_i);
            unique case (op)
                PUSH: begin
                    wp    <= wp + ONE;
                    count <= count + CONE;
                end
                POP: begin
`ifdef PARAM_STACK_FIFO_MODE_EN
                    if (is_fifo) rp <= rp + ONE;
                    else         wp <= wp - ONE;
`else
                    wp <= wp - ONE;
`endif
                    count <= count - CONE;
                end
                REPLACE: begin
`ifdef PARAM_STACK_FIFO_MODE_EN
                    if (is_fifo) begin
                        wp <= wp + ONE;
                        rp <= rp + ONE;
                    end
`endif
                end
                default: ;
            endcase
`ifdef PARAM_STACK_FIFO_MODE_EN
            if (empty && !push_i) mode_q <= mode_e'(mode_i);
`endif
        end
    end

    assign top_o   = empty ? '0 : rdata;
    assign count_o = count;
    assign empty_o = empty;
    assign full_o  = full;
    assign ovf_o   = ovf;
    assign udf_o   = udf;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (WIDTH=8, DEPTH=4) against a queue model.
// FIFO scenarios are built only when PARAM_STACK_FIFO_MODE_EN is defined.
module tb_param_stack;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         push_i = 1'b0;
    logic         pop_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         mode_i = 1'b0;
    logic         clr_err_i = 1'b0;
    logic [W-1:0] top_o;
    logic [2:0]   count_o;
    logic         empty_o, full_o, ovf_o, udf_o;

    param_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_i),
        .pop_i     (pop_i),
        .data_i    (data_i),
`ifdef PARAM_STACK_FIFO_MODE_EN
        .mode_i    (mode_i),
`endif
        .clr_err_i (clr_err_i),
        .top_o     (top_o),
        .count_o   (count_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .ovf_o     (ovf_o),
        .udf_o     (udf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q[$];
    bit m_fifo = 0;
    bit m_ovf = 0;
    bit m_udf = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_top();
        if (q.size() == 0) return '0;
        return m_fifo ? q[0] : q[q.size()-1];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".top"},   32'(top_o),   32'(m_top()));
        chk({tag, ".count"}, 32'(count_o), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full_o),  32'(q.size() == D));
        chk({tag, ".ovf"},   32'(ovf_o),   32'(m_ovf));
        chk({tag, ".udf"},   32'(udf_o),   32'(m_udf));
    endtask

    // Apply behavioural rules to the queue model for one edge
    task automatic model_step(input bit pu, input bit po,
                              input logic [W-1:0] d, input bit clr,
                              input bit md);
        bit no = 0, nu = 0;
        bit was_empty = (q.size() == 0);
        if (pu && po && !was_empty) begin
            if (m_fifo) void'(q.pop_front());
            else        void'(q.pop_back());
            q.push_back(d);
        end else if (pu) begin
            if (q.size() < D) q.push_back(d);
            else              no = 1;
        end else if (po) begin
            if (was_empty)   nu = 1;
            else if (m_fifo) void'(q.pop_front());
            else             void'(q.pop_back());
        end
        m_ovf = no | (m_ovf & !clr);
        m_udf = nu | (m_udf & !clr);
`ifdef PARAM_STACK_FIFO_MODE_EN
        if (was_empty && !pu) m_fifo = md;
`else
        if (md) m_fifo = 0;
`endif
    endtask

    task automatic step(input string tag, input bit pu, input bit po,
                        input logic [W-1:0] d, input bit clr, input bit md);
        push_i = pu;
        pop_i = po;
        data_i = d;
        clr_err_i = clr;
        mode_i = md;
        @(posedge clk);
        model_step(pu, po, d, clr, md);
        #1;
        check_all(tag);
        push_i = 0;
        pop_i = 0;
        clr_err_i = 0;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("r30_p1", 1, 0, 8'h11, 0, 0);
        step("r30_p2", 1, 0, 8'h22, 0, 0);
        step("r30_p3", 1, 0, 8'h33, 0, 0);
        chk("r30_top33", 32'(top_o), 32'h33);
        step("r30_o1", 0, 1, 8'h00, 0, 0);
        chk("r30_top22", 32'(top_o), 32'h22);
        step("r30_o2", 0, 1, 8'h00, 0, 0);
        step("r30_o3", 0, 1, 8'h00, 0, 0);
        chk("r30_empty", 32'(empty_o), 32'd1);

        for (int i = 0; i < 4; i++) step("r31_fill", 1, 0, 8'(8'hA0 + i), 0, 0);
        step("r31_ovf", 1, 0, 8'h55, 0, 0);
        chk("r31_ovf_set", 32'(ovf_o), 32'd1);
        step("r31_repl_full", 1, 1, 8'h66, 0, 0);
        for (int i = 0; i < 4; i++) step("r31_drain", 0, 1, 8'h00, 0, 0);
        step("r31_udf", 0, 1, 8'h00, 0, 0);
        chk("r31_udf_set", 32'(udf_o), 32'd1);
        step("r21_pp_empty", 1, 1, 8'h77, 0, 0);
        step("r31_clr", 0, 0, 8'h00, 1, 0);
        step("r24_clr_wins", 0, 1, 8'h00, 1, 0);
        step("r24_clr_wins2", 0, 1, 8'h00, 1, 0);
        step("r24_clr", 0, 0, 8'h00, 1, 0);

        step("r32_a1", 1, 0, 8'hA1, 0, 0);
        step("r32_b2", 1, 0, 8'hB2, 0, 0);
        step("r32_c3", 1, 1, 8'hC3, 0, 0);
        chk("r32_topC3", 32'(top_o), 32'hC3);
        step("r32_pop", 0, 1, 8'h00, 0, 0);
        chk("r32_topA1", 32'(top_o), 32'hA1);
        step("r32_pop2", 0, 1, 8'h00, 0, 0);

`ifdef PARAM_STACK_FIFO_MODE_EN
        step("r33_mode", 0, 0, 8'h00, 0, 1);
        step("r33_p1", 1, 0, 8'h01, 0, 1);
        step("r33_p2", 1, 0, 8'h02, 0, 0);
        step("r33_p3", 1, 0, 8'h03, 0, 0);
        for (int i = 4; i <= 6; i++) step("r33_pp", 1, 1, 8'(i), 0, 0);
        for (int i = 0; i < 3; i++) step("r33_drain", 0, 1, 8'h00, 0, 1);
        step("r33_idle", 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step("r33_wrap", 1, 0, 8'(8'h40 + i), 0, 0);
        step("r33_pop", 0, 1, 8'h00, 0, 0);
        while (q.size() > 0) step("r33_empty", 0, 1, 8'h00, 0, 0);
        step("r33_lifo", 0, 0, 8'h00, 0, 0);
`endif

        for (int i = 0; i < 3; i++) step("r34_fill", 1, 0, 8'(8'h90 + i), 0, 0);
        push_i = 1;
        data_i = 8'hEE;
        @(posedge clk);
        model_step(1, 0, 8'hEE, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_fifo = 0;
        m_ovf = 0;
        m_udf = 0;
        check_all("r34_async");
        push_i = 0;
        @(negedge clk);
        rst = 1'b0;
        step("r34_first", 1, 0, 8'h5A, 0, 0);
        chk("r34_top", 32'(top_o), 32'h5A);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
